// File: rtl/posit_mult_pkg.sv
// Shared constants for the posit multiplier: special encodings built at a
// fixed maximum width and sliced down to N bits by each user.
package posit_mult_pkg;

    localparam int MAX_N = 64;

    function automatic logic [MAX_N-1:0] width_mask(input int n);
        return ~({MAX_N{1'b1}} << n);
    endfunction

    function automatic logic [MAX_N-1:0] posit_nar(input int n);
        logic [MAX_N-1:0] r;
        r        = {MAX_N{1'b0}};
        r[n-1]   = 1'b1;
        return r;
    endfunction

    function automatic logic [MAX_N-1:0] posit_zero(input int n);
        return {MAX_N{1'b0}} & width_mask(n);
    endfunction

    function automatic logic [MAX_N-1:0] posit_maxpos(input int n);
        return {MAX_N{1'b1}} >> (MAX_N - n + 1);
    endfunction

    function automatic logic [MAX_N-1:0] posit_minpos(input int n);
        return {{(MAX_N-1){1'b0}}, 1'b1} & width_mask(n);
    endfunction

endpackage

// File: rtl/posit_mult_decode.sv
// Posit operand decoder: sign, regime value k, exponent, fraction and the
// zero/NaR special cases of one N-bit posit.
module posit_decode
    import posit_mult_pkg::*;
#(
    parameter int N  = 16,
    parameter int es = 1,
    parameter int KW = $clog2(N) + 2,
    parameter int EW = (es > 0) ? es : 1,
    parameter int FW = N - 1 - es
) (
    input  logic [N-1:0]         p,
    output logic                 sign,
    output logic                 is_zero,
    output logic                 is_nar,
    output logic signed [KW-1:0] k,
    output logic [EW-1:0]        e,
    output logic [FW-1:0]        frac
);

    localparam int CW = KW - 1;
    localparam logic [MAX_N-1:0] NAR_W  = posit_nar(N);
    localparam logic [MAX_N-1:0] ZERO_W = posit_zero(N);
    localparam logic [N-1:0]     NAR_C  = NAR_W[N-1:0];
    localparam logic [N-1:0]     ZERO_C = ZERO_W[N-1:0];
    localparam logic [N-2:0]     ONE_B  = {{(N-2){1'b0}}, 1'b1};

    logic [N-2:0]         body;
    logic [N-2:0]         rem;
    logic                 rbit;
    logic                 run;
    logic [CW-1:0]        m;
    logic signed [KW-1:0] mk;

    // Field extraction: regime run length, then exponent and fraction left-aligned
    always_comb begin
        sign    = p[N-1];
        is_zero = (p == ZERO_C);
        is_nar  = (p == NAR_C);
        // The low N-1 bits of the two's complement are all the magnitude we need
        body    = p[N-1] ? (~p[N-2:0] + ONE_B) : p[N-2:0];
        rbit    = body[N-2];
        m       = {CW{1'b0}};
        run     = 1'b1;
        for (int i = N - 2; i >= 0; i--) begin
            if (run && (body[i] == rbit)) begin
                m = m + CW'(1);
            end else begin
                run = 1'b0;
            end
        end
        rem = body << (m + CW'(1));
        mk  = $signed({1'b0, m});
        if (rbit) begin
            k = mk - $signed(KW'(1));
        end else begin
            k = -mk;
        end
        e    = (es > 0) ? rem[N-2 -: EW] : {EW{1'b0}};
        frac = rem[FW-1:0];
    end

endmodule

// File: rtl/posit_mult.sv
// Single-stage posit multiplier: two decoders, combinational multiply,
// normalise, re-encode and round-to-nearest-even, then one output register.
module posit_mult
    import posit_mult_pkg::*;
#(
    parameter int N  = 16,
    parameter int es = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    input  logic         start,
    output logic [N-1:0] out,
    output logic         inf,
    output logic         zero,
    output logic         done
);

    localparam int KW = $clog2(N) + 2;
    localparam int EW = (es > 0) ? es : 1;
    localparam int FW = N - 1 - es;
    localparam int PW = 2 * FW + 2;
    localparam int MW = PW - 1;
    localparam int SW = $clog2(N) + es + 5;
    localparam int TW = es + MW;
    localparam int XW = 1 + TW + N;

    localparam logic [MAX_N-1:0] NAR_W  = posit_nar(N);
    localparam logic [MAX_N-1:0] ZERO_W = posit_zero(N);
    localparam logic [MAX_N-1:0] MAXP_W = posit_maxpos(N);
    localparam logic [MAX_N-1:0] MINP_W = posit_minpos(N);
    localparam logic [N-1:0]     NAR_C  = NAR_W[N-1:0];
    localparam logic [N-1:0]     ZERO_C = ZERO_W[N-1:0];
    localparam logic [N-1:0]     MAXP_C = MAXP_W[N-1:0];
    localparam logic [N-1:0]     MINP_C = MINP_W[N-1:0];
    localparam logic [N-1:0]     ONE_C  = {{(N-1){1'b0}}, 1'b1};
    localparam logic signed [SW-1:0] K_MAX = SW'(N - 2);
    localparam logic signed [SW-1:0] K_MIN = -K_MAX;

    logic                 sign_a, zero_a, nar_a;
    logic                 sign_b, zero_b, nar_b;
    logic signed [KW-1:0] k_a, k_b;
    logic [EW-1:0]        e_a, e_b;
    logic [FW-1:0]        frac_a, frac_b;

    logic [FW:0]          sig_a, sig_b;
    logic [PW-1:0]        prod;
    logic                 ovf;
    logic [MW-1:0]        mant;
    logic signed [SW-1:0] scale;
    logic signed [SW-1:0] k_r;
    logic signed [SW-1:0] e_low;
    logic [SW-1:0]        run_len;
    logic [TW-1:0]        tail;
    logic [XW-1:0]        x_v, fill, y;
    logic [N-2:0]         body, body_r;
    logic                 guard, sticky, rnd;
    logic [N-1:0]         mag, res;

    logic [N-1:0] out_d, out_q;
    logic         inf_d, inf_q;
    logic         zero_d, zero_q;
    logic         done_d, done_q;

    posit_decode #(.N(N), .es(es)) u_dec_a (
        .p       (in1),
        .sign    (sign_a),
        .is_zero (zero_a),
        .is_nar  (nar_a),
        .k       (k_a),
        .e       (e_a),
        .frac    (frac_a)
    );

    posit_decode #(.N(N), .es(es)) u_dec_b (
        .p       (in2),
        .sign    (sign_b),
        .is_zero (zero_b),
        .is_nar  (nar_b),
        .k       (k_b),
        .e       (e_b),
        .frac    (frac_b)
    );

    // Multiply significands, normalise, rebuild regime/exponent/fraction and round
    always_comb begin
        sig_a = {1'b1, frac_a};
        sig_b = {1'b1, frac_b};
        prod  = PW'(sig_a) * PW'(sig_b);
        ovf   = prod[PW-1];
        mant  = ovf ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
        scale = ((SW'(k_a) + SW'(k_b)) <<< es) + SW'(e_a) + SW'(e_b) + SW'(ovf);
        k_r   = scale >>> es;
        e_low = scale - (k_r <<< es);
        tail  = (TW'(e_low) << MW) | TW'(mant);
        // The regime is the run of fill bits in front of the terminator bit
        run_len = k_r[SW-1] ? -k_r : (k_r + SW'(1));
        x_v     = {k_r[SW-1], tail, {N{1'b0}}};
        fill    = k_r[SW-1] ? {XW{1'b0}} : ~({XW{1'b1}} >> run_len);
        y       = (x_v >> run_len) | fill;
        body    = y[XW-1 -: N-1];
        guard   = y[XW-N];
        sticky  = |y[XW-N-1:0];
        rnd     = guard & (sticky | body[0]) & ~(&body);
        body_r  = body + {{(N-2){1'b0}}, rnd};
        if (k_r > K_MAX) begin
            mag = MAXP_C;
        end else if (k_r < K_MIN) begin
            mag = MINP_C;
        end else begin
            mag = {1'b0, body_r};
        end
        res = (sign_a ^ sign_b) ? (~mag + ONE_C) : mag;
    end

    // Next output state: capture a result on start, otherwise hold it
    always_comb begin
        done_d = start;
        if (start) begin
            if (nar_a || nar_b) begin
                out_d  = NAR_C;
                inf_d  = 1'b1;
                zero_d = 1'b0;
            end else if (zero_a || zero_b) begin
                out_d  = ZERO_C;
                inf_d  = 1'b0;
                zero_d = 1'b1;
            end else begin
                out_d  = res;
                inf_d  = 1'b0;
                zero_d = 1'b0;
            end
        end else begin
            out_d  = out_q;
            inf_d  = inf_q;
            zero_d = zero_q;
        end
    end

    // Output register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= {N{1'b0}};
            inf_q  <= 1'b0;
            zero_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            inf_q  <= inf_d;
            zero_q <= zero_d;
            done_q <= done_d;
        end
    end

    assign out  = out_q;
    assign inf  = inf_q;
    assign zero = zero_q;
    assign done = done_q;

endmodule

// File: tb/tb_posit_mult.sv
// Self-checking bench for posit_mult: directed cases, a wide configuration,
// randomized back-to-back traffic against a real-valued posit model, and reset.
module tb_posit_mult;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in1, in2, out;
    logic        start, inf, zero, done;
    logic [32:0] w_in1, w_in2, w_out;
    logic        w_start, w_inf, w_zero, w_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    posit_mult #(.N(16), .es(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in1(in1), .in2(in2), .start(start),
        .out(out), .inf(inf), .zero(zero), .done(done)
    );

    posit_mult #(.N(33), .es(5)) u_wide (
        .clk(clk), .rst_n(rst_n), .in1(w_in1), .in2(w_in2), .start(w_start),
        .out(w_out), .inf(w_inf), .zero(w_zero), .done(w_done)
    );

    function automatic real pow2(input int s);
        real r = 1.0;
        if (s >= 0) begin
            for (int i = 0; i < s; i++) r = r * 2.0;
        end else begin
            for (int i = 0; i < -s; i++) r = r / 2.0;
        end
        return r;
    endfunction

    // Value of an n-bit posit, read field by field
    function automatic real pval(input longint unsigned p_in, input int n, input int es);
        longint unsigned mask, p, mag;
        int  i, m, k, e;
        bit  r, neg;
        real f, w, s;
        mask = (64'd1 << n) - 64'd1;
        p    = p_in & mask;
        if (p == 64'd0) return 0.0;
        neg = p[n-1];
        mag = neg ? ((~p + 64'd1) & mask) : p;
        i = n - 2;
        r = mag[i];
        m = 0;
        while (i >= 0 && mag[i] == r) begin
            m++;
            i--;
        end
        i--;
        k = r ? m - 1 : -m;
        e = 0;
        for (int j = 0; j < es; j++) begin
            e = e * 2 + ((i >= 0 && mag[i]) ? 1 : 0);
            i--;
        end
        f = 1.0;
        w = 0.5;
        while (i >= 0) begin
            if (mag[i]) f = f + w;
            w = w / 2.0;
            i--;
        end
        s = f * pow2(k * (1 << es) + e);
        return neg ? -s : s;
    endfunction

    // Reference product for N=16, es=1: exact real product, nearest posit by search
    function automatic void model16(input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] o, output logic o_inf,
                                    output logic o_zero);
        real x, midv;
        bit  neg;
        int  lo, hi, md;
        logic [15:0] p;
        if (a == 16'h8000 || b == 16'h8000) begin
            o = 16'h8000; o_inf = 1'b1; o_zero = 1'b0;
            return;
        end
        if (a == 16'h0000 || b == 16'h0000) begin
            o = 16'h0000; o_inf = 1'b0; o_zero = 1'b1;
            return;
        end
        x   = pval(a, 16, 1) * pval(b, 16, 1);
        neg = (x < 0.0);
        if (neg) x = -x;
        if (x <= pval(1, 16, 1)) begin
            lo = 1;
        end else if (x >= pval(16'h7FFF, 16, 1)) begin
            lo = 32767;
        end else begin
            lo = 1;
            hi = 32766;
            while (lo < hi) begin
                md = (lo + hi + 1) / 2;
                if (pval(md, 16, 1) <= x) lo = md;
                else hi = md - 1;
            end
            if (pval(lo, 16, 1) != x) begin
                // Midpoint in bit-string terms is the 17-bit posit with a 1 appended
                midv = pval(longint'(lo) * 2 + 1, 17, 1);
                if (x > midv || (x == midv && (lo % 2) == 1)) lo++;
            end
        end
        p = 16'(lo);
        o = neg ? (~p + 16'd1) : p;
        o_inf = 1'b0;
        o_zero = 1'b0;
    endfunction

    task automatic op16(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        in1 = a;
        in2 = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; w_start = 1'b0;
        in1 = 16'h0; in2 = 16'h0; w_in1 = 33'h0; w_in2 = 33'h0;
        #12;
        checks++;
        if ({out, inf, zero, done} !== 19'h0) begin
            errors++;
            $display("FAIL reset16: got out=%h inf=%b zero=%b done=%b, expected all 0", out, inf, zero, done);
        end
        checks++;
        if ({w_out, w_inf, w_zero, w_done} !== 36'h0) begin
            errors++;
            $display("FAIL reset33: got out=%h done=%b, expected all 0", w_out, w_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL idle_done: got %b expected 0", done);
        end
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] o;
        logic        f_inf;
        logic        f_zero;
    } vec_t;

    task automatic test_directed();
        vec_t v [10];
        v[0] = '{16'h4800, 16'h4800, 16'h5200, 1'b0, 1'b0};
        v[1] = '{16'h4000, 16'h4000, 16'h4000, 1'b0, 1'b0};
        v[2] = '{16'hC000, 16'h4800, 16'hB800, 1'b0, 1'b0};
        v[3] = '{16'h8000, 16'h4000, 16'h8000, 1'b1, 1'b0};
        v[4] = '{16'h0000, 16'h4800, 16'h0000, 1'b0, 1'b1};
        v[5] = '{16'h8000, 16'h0000, 16'h8000, 1'b1, 1'b0};
        v[6] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0};
        v[7] = '{16'h0001, 16'h0001, 16'h0001, 1'b0, 1'b0};
        v[8] = '{16'h8001, 16'h7FFF, 16'h8001, 1'b0, 1'b0};
        v[9] = '{16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            op16(v[i].a, v[i].b);
            checks++;
            if ({out, inf, zero, done} !== {v[i].o, v[i].f_inf, v[i].f_zero, 1'b1}) begin
                errors++;
                $display("FAIL directed[%0d] %h*%h: got out=%h inf=%b zero=%b done=%b, expected out=%h inf=%b zero=%b done=1",
                         i, v[i].a, v[i].b, out, inf, zero, done, v[i].o, v[i].f_inf, v[i].f_zero);
            end
        end
    endtask

    task automatic test_hold();
        op16(16'hC000, 16'h4800);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({out, inf, zero, done} !== {16'hB800, 1'b0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL hold[%0d]: got out=%h done=%b, expected out=b800 done=0", i, out, done);
            end
        end
    endtask

    task automatic test_wide();
        @(negedge clk);
        w_in1 = {8'b0011_1111, 25'b0};
        w_in2 = {8'b0011_1111, 25'b0};
        w_start = 1'b1;
        @(negedge clk);
        w_start = 1'b0;
        checks++;
        if ({w_out, w_inf, w_zero, w_done} !== {8'b0011_1110, 25'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL wide_half_sq: got out=%h inf=%b zero=%b done=%b, expected out=%h done=1",
                     w_out, w_inf, w_zero, w_done, {8'b0011_1110, 25'b0});
        end
    endtask

    function automatic logic [15:0] pick_operand();
        int sel = $urandom_range(0, 11);
        case (sel)
            0:       return 16'h8000;
            1:       return 16'h0000;
            2:       return 16'(16'h7FF0 | 16'($urandom_range(0, 15)));
            3:       return 16'($urandom_range(1, 15));
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic test_back_to_back();
        logic [15:0] a, b, eo;
        logic        ei, ez;
        for (int i = 0; i <= 400; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if ({out, inf, zero, done} !== {eo, ei, ez, 1'b1}) begin
                    errors++;
                    $display("FAIL random[%0d] %h*%h: got out=%h inf=%b zero=%b done=%b, expected out=%h inf=%b zero=%b",
                             i - 1, a, b, out, inf, zero, done, eo, ei, ez);
                end
            end
            if (i < 400) begin
                a = pick_operand();
                b = pick_operand();
                in1 = a;
                in2 = b;
                start = 1'b1;
                model16(a, b, eo, ei, ez);
            end else begin
                start = 1'b0;
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        in1 = 16'h4800; in2 = 16'h4800; start = 1'b1;
        @(posedge clk);
        #2;
        checks++;
        if ({out, done} !== {16'h5200, 1'b1}) begin
            errors++;
            $display("FAIL pre_reset: got out=%h done=%b, expected out=5200 done=1", out, done);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out, inf, zero, done} !== 19'h0) begin
            errors++;
            $display("FAIL async_reset: got out=%h inf=%b zero=%b done=%b, expected all 0", out, inf, zero, done);
        end
        checks++;
        if ({w_out, w_inf, w_zero, w_done} !== 36'h0) begin
            errors++;
            $display("FAIL async_reset33: got out=%h done=%b, expected all 0", w_out, w_done);
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({out, done} !== {16'h0000, 1'b0}) begin
            errors++;
            $display("FAIL discard_after_reset: got out=%h done=%b, expected out=0000 done=0", out, done);
        end
        op16(16'h4000, 16'h4000);
        checks++;
        if ({out, inf, zero, done} !== {16'h4000, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL first_after_reset: got out=%h done=%b, expected out=4000 done=1", out, done);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_wide();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/posit_mult.md
POSIT_MULT -- requirements
Module: posit_mult

Interface
REQ-001 SHALL have parameter N, default 16, total posit width in bits (N >= 8).
REQ-002 SHALL have parameter es, default 1, exponent field width in bits (es <= N-4).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port in1, input, N bits: posit operand A (two's-complement posit encoding).
REQ-006 SHALL have port in2, input, N bits: posit operand B.
REQ-007 SHALL have port start, input, 1 bit: operands valid this cycle; request a multiply.
REQ-008 SHALL have port out, output, N bits: registered posit product.
REQ-009 SHALL have port inf, output, 1 bit: registered flag, result is NaR (encoding 1 followed by N-1 zeros).
REQ-010 SHALL have port zero, output, 1 bit: registered flag, result is zero.
REQ-011 SHALL have port done, output, 1 bit: registered flag, out/inf/zero are valid.

Function
REQ-012 SHALL sample in1/in2 on each rising clk edge where start=1 and present out, inf, zero and done=1 after that edge (latency 1 cycle); a new operation may start every cycle.
REQ-013 SHALL drive done=0 after any edge where start=0, and SHALL hold out/inf/zero at their last values.
REQ-014 SHALL decode each operand: sign = MSB; magnitude = two's complement if negative; regime run length gives k (run of m ones -> k=m-1; run of m zeros -> k=-m); next es bits = exponent e (missing bits read as 0); remaining bits = fraction with hidden 1.
REQ-015 SHALL compute result sign = XOR of signs; scale = (kA+kB)*2^es + eA + eB; mantissa product of the two (1.f) significands, renormalised (scale+1 when product >= 2).
REQ-016 SHALL re-encode the result as regime/exponent/fraction and round to nearest, ties to even, using guard and sticky bits over all discarded bits.
REQ-017 SHALL saturate: a magnitude above maxpos gives maxpos (0 followed by N-1 ones); a nonzero magnitude below minpos gives minpos (N-1 zeros then 1); rounding SHALL never produce zero or NaR from finite nonzero operands.
REQ-018 SHALL negate (two's complement) the encoded magnitude when the result sign is 1.
REQ-019 SHALL give inf=1 and out = NaR if either operand is NaR, including NaR x 0.
REQ-020 SHALL otherwise give zero=1 and out=0 if either operand is 0.
REQ-021 SHALL clear inf and zero for all other results; inf and zero are never both 1.

Reset
REQ-022 SHALL, while rst_n=0, clear out, inf, zero and done to 0 immediately, without waiting for a clk edge.
REQ-023 SHALL discard any operation sampled before the reset; the first valid result after reset release is one cycle after the first start=1 edge.

Structure
REQ-024 SHALL place in a shared package: functions for the NaR and zero constants, and the maxpos/minpos encodings parameterised by N.
REQ-025 SHALL implement operand decode as one sub-module, posit_decode, instantiated twice. It contains the leading-one/zero count, the regime, exponent and fraction extraction, and the zero/NaR detection.
REQ-026 SHALL implement the multiply, normalise, encode and round datapath as combinational logic feeding a single register stage.

Verification
REQ-027 SHALL cover N=33, es=5: in1=in2={8'b0011_1111, 25'b0} (0.5), start=1 -> next cycle out={8'b0011_1110, 25'b0} (0.25), done=1, inf=0, zero=0.
REQ-028 SHALL cover defaults: 0x4800 x 0x4800 (1.5 x 1.5) -> 0x5200 (2.25), and 0x4000 x 0x4000 -> 0x4000.
REQ-029 SHALL cover sign: 0xC000 x 0x4800 (-1.0 x 1.5) -> 0xB800 (-1.5).
REQ-030 SHALL cover specials: 0x8000 x 0x4000 -> 0x8000 with inf=1; 0x0000 x 0x4800 -> 0x0000 with zero=1; 0x8000 x 0x0000 -> 0x8000 with inf=1.
REQ-031 SHALL cover saturation: 0x7FFF x 0x7FFF -> 0x7FFF, and 0x0001 x 0x0001 -> 0x0001.
REQ-032 SHALL cover reset: assert rst_n=0 mid-stream between clock edges -> out/inf/zero/done read 0 immediately; start=0 cycles -> done=0.
